// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 8-bit LCD power-up, init and 14-char frame-write sequencer
// Optional auto-refresh in IDLE: define LCD_CTRL_AUTOREFRESH_EN.
module lcd_ctrl #(
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_CYC        = 12,
    parameter int unsigned WAIT_CYC     = 2000,
`ifdef LCD_CTRL_AUTOREFRESH_EN
    parameter int unsigned REFRESH_CYC  = 2500000,
`endif
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_req,
    input  logic [2:0] op_sel,
    output logic       busy,
    output logic       done,
    output logic [1:0] init_sel,
    output logic       data_sel,
    output logic       DB_sel,
    output logic [1:0] state,
    output logic [2:0] statelocal,
    output logic [1:0] index,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);
    typedef enum logic [1:0] {T_PWRUP, T_INIT, T_IDLE, T_FRAME} top_t;
    typedef enum logic [1:0] {P_SETUP, P_EHIGH, P_WAIT} ph_t;
    typedef struct packed {
        logic       ds;
        logic [1:0] is;
        logic [1:0] st;
        logic [2:0] sl;
        logic [1:0] ix;
    } sel_t;

    top_t        top;
    ph_t         ph;
    logic [31:0] cnt;
    logic [3:0]  item;
    logic [2:0]  op_q;
    logic        pending;
    sel_t        sel_q;

    // Init order is functionSet, displayOn, entryMode, clear; frame item 0 is clear.
    function automatic sel_t item_sel(input logic frame, input logic [3:0] n, input logic [2:0] op);
        sel_t s;
        s = '0;
        if (!frame) begin
            case (n[1:0])
                2'd0:    s.is = 2'd3;
                2'd1:    s.is = 2'd1;
                2'd2:    s.is = 2'd2;
                default: s.is = 2'd0;
            endcase
        end else if (n != 4'd0) begin
            s.ds = 1'b1;
            if (n <= 4'd4) begin
                s.ix = 2'(n - 4'd1);
            end else if (n == 4'd5 || n == 4'd10) begin
                s.st = 2'd2;
            end else if (n <= 4'd9) begin
                s.sl = 3'd1;
                s.ix = 2'(n - 4'd6);
            end else begin
                s.st = 2'd1;
                s.sl = op;
                s.ix = 2'(n - 4'd11);
            end
        end
        return s;
    endfunction

    logic        in_frame, is_clear, is_last, wait_end, auto_hit, go_frame;
    logic [31:0] wait_lim;
    sel_t        sel_next;

    always_comb begin
        in_frame = (top == T_FRAME);
        is_clear = in_frame ? (item == 4'd0) : (item == 4'd3);
        is_last  = in_frame ? (item == 4'd14) : (item == 4'd3);
        wait_lim = is_clear ? CLR_WAIT_CYC : WAIT_CYC;
        wait_end = (top == T_INIT || top == T_FRAME) && (ph == P_WAIT) && (cnt == wait_lim - 32'd1);
        go_frame = ((top == T_IDLE) && (refresh_req || pending || auto_hit)) ||
                   (in_frame && wait_end && is_last && (pending || refresh_req));
        sel_next = item_sel(in_frame, item + 4'd1, op_q);
    end

`ifdef LCD_CTRL_AUTOREFRESH_EN
    logic [31:0] rcnt;
    assign auto_hit = (top == T_IDLE) && (rcnt == REFRESH_CYC - 1);

    always_ff @(posedge clk) begin
        if (rst || go_frame) begin
            rcnt <= '0;
        end else if (top == T_IDLE) begin
            rcnt <= rcnt + 32'd1;
        end
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            top     <= T_PWRUP;
            ph      <= P_SETUP;
            cnt     <= '0;
            item    <= '0;
            op_q    <= '0;
            pending <= 1'b0;
            sel_q   <= item_sel(1'b0, 4'd0, 3'd0);
            busy    <= 1'b1;
            done    <= 1'b0;
            LCD_E   <= 1'b0;
            DB_sel  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (refresh_req && top != T_IDLE) pending <= 1'b1;
            case (top)
                T_PWRUP: begin
                    if (cnt == PWRUP_CYC) begin
                        cnt    <= '0;
                        top    <= T_INIT;
                        ph     <= P_SETUP;
                        item   <= '0;
                        sel_q  <= item_sel(1'b0, 4'd0, 3'd0);
                        DB_sel <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                T_IDLE: busy <= 1'b0;
                default: begin
                    case (ph)
                        P_SETUP: begin
                            if (cnt == SETUP_CYC - 1) begin
                                cnt   <= '0;
                                ph    <= P_EHIGH;
                                LCD_E <= 1'b1;
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end
                        P_EHIGH: begin
                            if (cnt == E_CYC - 1) begin
                                cnt    <= '0;
                                ph     <= P_WAIT;
                                LCD_E  <= 1'b0;
                                DB_sel <= 1'b0;
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end
                        default: begin
                            if (wait_end) begin
                                cnt <= '0;
                                if (!is_last) begin
                                    item   <= item + 4'd1;
                                    ph     <= P_SETUP;
                                    sel_q  <= sel_next;
                                    DB_sel <= 1'b1;
                                end else if (!in_frame) begin
                                    top  <= T_IDLE;
                                    busy <= pending | refresh_req;
                                end else begin
                                    done <= 1'b1;
                                    top  <= T_IDLE;
                                    busy <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + 32'd1;
                            end
                        end
                    endcase
                end
            endcase
            // Frame start wins over the IDLE/done bookkeeping above.
            if (go_frame) begin
                top     <= T_FRAME;
                ph      <= P_SETUP;
                item    <= '0;
                cnt     <= '0;
                op_q    <= op_sel;
                sel_q   <= item_sel(1'b1, 4'd0, op_sel);
                pending <= 1'b0;
                busy    <= 1'b1;
                DB_sel  <= 1'b1;
            end
        end
    end

    assign init_sel   = sel_q.is;
    assign data_sel   = sel_q.ds;
    assign state      = sel_q.st;
    assign statelocal = sel_q.sl;
    assign index      = sel_q.ix;
    assign LCD_RS     = sel_q.ds;
    assign LCD_RW     = 1'b0;
endmodule
